wb_matmul_engine: RTL
=====================

// Module: wb_matmul_engine
// PURPOSE
//  Wishbone-slave matrix multiply accelerator: C[MxN] = A[MxK] * B[KxN].
//  Generalises the fixed 8x8/32-bit multiplier: parametrised data width and
//  max dims, signed/unsigned mode, status register, single-edge datapath.
//  Sits on the SoC Wishbone bus as a memory-mapped peripheral.
// PARAMETERS
//  DW     32  operand/result width (bits)
//  MAX_M  8   max rows of A; MAX_M*MAX_N <= 256
//  MAX_K  8   max cols of A / rows of B; MAX_M*MAX_K, MAX_K*MAX_N <= 256
//  MAX_N  8   max cols of B
// PORTS
//  i_wb_clk    in   1   clock, all logic on posedge only
//  i_wb_rst_n  in   1   synchronous reset, active low
//  i_wb_adr    in   32  byte address; [12:10] region, [9:2] word index
//  i_wb_dat    in   32  write data (low DW bits used for matrix words)
//  i_wb_we     in   1   write enable
//  i_wb_stb    in   1   strobe
//  o_wb_rdt    out  32  read data
//  o_wb_ack    out  1   acknowledge
// BEHAVIOUR
//  Reset (i_wb_rst_n=0 at posedge): o_wb_ack=0, o_wb_rdt=0, CTRL=0, STATUS=0,
//   FSM->IDLE; A/B/C contents not reset. Reset mid-run aborts, no C writes.
//  Bus: o_wb_ack <= stb & !o_wb_ack (1-cycle latency, no back-to-back ack).
//   Reads: o_wb_rdt registered with ack; unmapped region/index reads 0.
//  Map [12:10]: 0 CTRL rw: [7:0]M [15:8]K [23:16]N [25]SGN; bit24 START is
//   write-only, self-clearing, reads 0.  1 A wo, idx=i*K+k.  2 B wo, idx=k*N+j.
//   3 C ro, idx=i*N+j.  4 STATUS ro: [0]DONE [1]BUSY [2]ERR.  5-7 ignored.
//  While BUSY: writes to CTRL/A/B ignored (acked); C reads return stale data.
//  START in IDLE: if M,K,N in 1..MAX_* -> BUSY=1, DONE=0, ERR=0, go LOAD;
//   else ERR=1, DONE=0, stay IDLE.
//  FSM: IDLE -> LOAD (issue A[i*K+k],B[k*N+j] reads, 1-cycle sync read) ->
//   MAC (acc += a*b each cycle, k=0..K-1, reads pipelined) -> STORE
//   (C[i*N+j]<=acc, acc<=0, advance j then i) -> LOAD or FIN -> IDLE.
//  FIN: BUSY=0, DONE=1. DONE clears on next accepted START.
//  Latency: START ack edge to DONE=1 is exactly M*N*(K+2)+1 cycles.
//  Arithmetic: SGN=1 two's complement, SGN=0 unsigned; product is 2*DW wide,
//   acc is 2*DW+8 wide; C gets low DW bits (wrap) unless MATMUL_SAT_EN.
//  Loop order row-major; index counters 8-bit, no wrap beyond MAX_*.
// CONFIGURATION
//  MATMUL_SAT_EN defined: C result saturates to DW range of selected mode
//   (signed: [-2^(DW-1), 2^(DW-1)-1]; unsigned: [0, 2^DW-1]); STATUS[3]
//   SATF set if any element of the run saturated, cleared on START.
//  Not defined: C = acc[DW-1:0] (modulo 2^DW); STATUS[3] reads 0.
// TESTING
//  2x2x2 unsigned, A=[1 2;3 4], B=[5 6;7 8], START -> DONE after 17 cycles,
//   C=[19 22;43 50].
//  SGN=1, 1x3x1, A=[-1 2 -3], B=[4 5 6] -> C=[-12] (0xFFFFFFF4 at DW=32).
//  CTRL M=0 or K=9 with START -> ERR=1, BUSY=0, C unchanged.
//  During BUSY: write A[0]=99 and second START -> ignored; result matches
//   pre-run A; ack still returned each access.
//  Unsigned 1x2x1 A=[0xFFFFFFFF,1], B=[2,1]: SAT_EN -> C=0xFFFFFFFF, SATF=1;
//   without -> C=0xFFFFFFFF (wrap: 0x1_FFFFFFFF low bits), SATF=0.
//  Assert i_wb_rst_n=0 mid-run -> next cycle BUSY=0, DONE=0, ack=0, rdt=0.

Source files
------------

// File: rtl/wb_matmul_engine.sv
// -----------------------------------------------------------------------------
// wb_matmul_engine
//
// Wishbone-slave matrix multiply accelerator computing C[MxN] = A[MxK] * B[KxN].
// A and B are loaded over the bus. A write to CTRL with START launches the run.
// The engine walks C in row-major order and computes one dot product per
// element. Results are read back from the C window. Progress is reported in
// STATUS.
//
// Address map (byte address; [12:10] region, [9:2] word index):
//   0 CTRL   rw  [7:0] M, [15:8] K, [23:16] N, [25] SGN, [24] START (wo, reads 0)
//   1 A      wo  idx = i*K + k
//   2 B      wo  idx = k*N + j
//   3 C      ro  idx = i*N + j
//   4 STATUS ro  [0] DONE, [1] BUSY, [2] ERR, [3] SATF
//   5..7     ignored, read 0
//
// Ports:
//   i_wb_clk    clock, all logic on the rising edge
//   i_wb_rst_n  synchronous reset, active low
//   i_wb_adr    byte address
//   i_wb_dat    write data (low DW bits used for matrix words)
//   i_wb_we     write enable
//   i_wb_stb    strobe
//   o_wb_rdt    registered read data
//   o_wb_ack    acknowledge, one cycle after strobe, never back-to-back
//
// Optional feature macro: MATMUL_SAT_EN
//   When defined, each C element saturates to the DW range of the selected
//   mode, and STATUS[3] (SATF) records whether any element of the run saturated.
//   When undefined, C keeps the low DW bits of the accumulator and SATF reads 0.
// -----------------------------------------------------------------------------
module wb_matmul_engine #(
  parameter int DW    = 32,
  parameter int MAX_M = 8,
  parameter int MAX_K = 8,
  parameter int MAX_N = 8
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  localparam int A_DEPTH = MAX_M * MAX_K;
  localparam int B_DEPTH = MAX_K * MAX_N;
  localparam int C_DEPTH = MAX_M * MAX_N;
  localparam int A_AW    = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int B_AW    = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int C_AW    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam int ACW     = 2 * DW + 8;
  localparam int PW      = 2 * DW + 2;

  localparam logic [8:0] LP_MAX_M   = 9'(MAX_M);
  localparam logic [8:0] LP_MAX_K   = 9'(MAX_K);
  localparam logic [8:0] LP_MAX_N   = 9'(MAX_N);
  localparam logic [8:0] LP_A_DEPTH = 9'(A_DEPTH);
  localparam logic [8:0] LP_B_DEPTH = 9'(B_DEPTH);
  localparam logic [8:0] LP_C_DEPTH = 9'(C_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_STORE,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Bus-side registers
  logic        r_ack;
  logic [31:0] r_rdt;

  // Configuration and status
  logic [7:0]  r_m;
  logic [7:0]  r_k;
  logic [7:0]  r_n;
  logic        r_sgn;
  logic        r_done;
  logic        r_err;
  logic        w_satf;

  // Loop counters; r_kr is the k index of the next operand read
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [8:0]  r_kr;

  // Operand memories and their registered read ports
  logic [DW-1:0] r_mem_a [0:A_DEPTH-1];
  logic [DW-1:0] r_mem_b [0:B_DEPTH-1];
  logic [DW-1:0] r_mem_c [0:C_DEPTH-1];
  logic [DW-1:0] r_a_q;
  logic [DW-1:0] r_b_q;

  logic signed [ACW-1:0] r_acc;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [2:0] w_region;
  logic [7:0] w_idx;
  logic       w_access;
  logic       w_busy;
  logic       w_wr;
  logic       w_ctrl_wr;
  logic       w_start;
  logic       w_dims_ok;
  logic       w_start_ok;
  logic       w_a_wr;
  logic       w_b_wr;

  assign w_region  = i_wb_adr[12:10];
  assign w_idx     = i_wb_adr[9:2];
  // An access is taken on the edge where ack rises, so it is counted once.
  assign w_access  = i_wb_stb & ~r_ack;
  assign w_busy    = (r_state != S_IDLE);
  assign w_wr      = w_access & i_wb_we;
  assign w_ctrl_wr = w_wr & (w_region == 3'd0) & (w_idx == 8'd0) & ~w_busy;
  assign w_start   = w_ctrl_wr & i_wb_dat[24];
  assign w_dims_ok = (i_wb_dat[7:0] != 8'd0)   & ({1'b0, i_wb_dat[7:0]}   <= LP_MAX_M) &
                     (i_wb_dat[15:8] != 8'd0)  & ({1'b0, i_wb_dat[15:8]}  <= LP_MAX_K) &
                     (i_wb_dat[23:16] != 8'd0) & ({1'b0, i_wb_dat[23:16]} <= LP_MAX_N);
  assign w_start_ok = w_start & w_dims_ok;
  assign w_a_wr = w_wr & (w_region == 3'd1) & ~w_busy & ({1'b0, w_idx} < LP_A_DEPTH);
  assign w_b_wr = w_wr & (w_region == 3'd2) & ~w_busy & ({1'b0, w_idx} < LP_B_DEPTH);

  // ---------------------------------------------------------------------------
  // Engine addressing
  // ---------------------------------------------------------------------------
  logic        w_rd_en;
  logic [15:0] w_a_lin;
  logic [15:0] w_b_lin;
  logic [15:0] w_c_lin;
  logic [A_AW-1:0] w_a_ridx;
  logic [B_AW-1:0] w_b_ridx;
  logic        w_last;
  logic        w_k_end;

  // Operand reads run one cycle ahead of the MAC. After the last k, the read
  // port is parked at 0 so the address never leaves the array.
  assign w_rd_en  = ((r_state == S_LOAD) || (r_state == S_MAC)) && (r_kr < {1'b0, r_k});
  assign w_a_lin  = {8'd0, r_i} * {8'd0, r_k} + {8'd0, r_kr[7:0]};
  assign w_b_lin  = {7'd0, r_kr} * {8'd0, r_n} + {8'd0, r_j};
  assign w_c_lin  = {8'd0, r_i} * {8'd0, r_n} + {8'd0, r_j};
  assign w_a_ridx = w_rd_en ? w_a_lin[A_AW-1:0] : '0;
  assign w_b_ridx = w_rd_en ? w_b_lin[B_AW-1:0] : '0;
  assign w_k_end  = (r_kr == {1'b0, r_k});
  assign w_last   = (r_j == r_n - 8'd1) && (r_i == r_m - 8'd1);

  // ---------------------------------------------------------------------------
  // Arithmetic: operands are extended by the mode sign so one signed multiplier
  // serves both the signed and the unsigned case.
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0]  w_a_x;
  logic signed [PW-1:0]  w_b_x;
  logic signed [PW-1:0]  w_prod;
  logic signed [ACW-1:0] w_prod_x;
  logic [DW-1:0]         w_c_val;
  logic                  w_sat;

  assign w_a_x    = $signed({{(DW + 2){r_sgn & r_a_q[DW-1]}}, r_a_q});
  assign w_b_x    = $signed({{(DW + 2){r_sgn & r_b_q[DW-1]}}, r_b_q});
  assign w_prod   = w_a_x * w_b_x;
  assign w_prod_x = $signed({{(ACW - PW){w_prod[PW-1]}}, w_prod});

`ifdef MATMUL_SAT_EN
  always_comb begin
    w_sat   = 1'b0;
    w_c_val = r_acc[DW-1:0];
    if (r_sgn) begin
      // In range only when every bit from DW-1 up is a copy of the sign.
      if (!((&r_acc[ACW-1:DW-1]) || ~(|r_acc[ACW-1:DW-1]))) begin
        w_sat   = 1'b1;
        w_c_val = r_acc[ACW-1] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
      end
    end else if (|r_acc[ACW-1:DW]) begin
      // Unsigned sums never go negative, so only the top clamp applies.
      w_sat   = 1'b1;
      w_c_val = '1;
    end
  end
`else
  assign w_sat   = 1'b0;
  assign w_c_val = r_acc[DW-1:0];
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_MAC;
      S_MAC:   if (w_k_end) w_state_next = S_STORE;
      S_STORE: w_state_next = w_last ? S_FIN : S_LOAD;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control, counters, accumulator
  // ---------------------------------------------------------------------------
`ifdef MATMUL_SAT_EN
  logic r_satf;
  assign w_satf = r_satf;
`else
  assign w_satf = 1'b0;
`endif

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      r_m    <= '0;
      r_k    <= '0;
      r_n    <= '0;
      r_sgn  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_i    <= '0;
      r_j    <= '0;
      r_kr   <= '0;
      r_acc  <= '0;
`ifdef MATMUL_SAT_EN
      r_satf <= 1'b0;
`endif
    end else begin
      if (w_ctrl_wr) begin
        r_m   <= i_wb_dat[7:0];
        r_k   <= i_wb_dat[15:8];
        r_n   <= i_wb_dat[23:16];
        r_sgn <= i_wb_dat[25];
      end
      if (w_start) begin
        r_done <= 1'b0;
        r_err  <= ~w_dims_ok;
        r_i    <= '0;
        r_j    <= '0;
        r_kr   <= '0;
        r_acc  <= '0;
`ifdef MATMUL_SAT_EN
        r_satf <= 1'b0;
`endif
      end
      case (r_state)
        S_LOAD: r_kr <= r_kr + 9'd1;
        S_MAC: begin
          r_acc <= r_acc + w_prod_x;
          if (!w_k_end) r_kr <= r_kr + 9'd1;
        end
        S_STORE: begin
          r_acc <= '0;
          r_kr  <= '0;
`ifdef MATMUL_SAT_EN
          r_satf <= r_satf | w_sat;
`endif
          if (r_j == r_n - 8'd1) begin
            r_j <= '0;
            r_i <= r_i + 8'd1;
          end else begin
            r_j <= r_j + 8'd1;
          end
        end
        S_FIN: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memories (contents are not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_wb_clk) begin
    if (w_a_wr) r_mem_a[w_idx[A_AW-1:0]] <= i_wb_dat[DW-1:0];
    r_a_q <= r_mem_a[w_a_ridx];
  end

  always_ff @(posedge i_wb_clk) begin
    if (w_b_wr) r_mem_b[w_idx[B_AW-1:0]] <= i_wb_dat[DW-1:0];
    r_b_q <= r_mem_b[w_b_ridx];
  end

  // A reset landing on a STORE edge must not commit a partial result.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst_n && (r_state == S_STORE)) r_mem_c[w_c_lin[C_AW-1:0]] <= w_c_val;
  end

  // ---------------------------------------------------------------------------
  // Bus response
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= i_wb_stb & ~r_ack;
      r_rdt <= '0;
      if (w_access && !i_wb_we) begin
        case (w_region)
          3'd0: if (w_idx == 8'd0) r_rdt <= {6'd0, r_sgn, 1'b0, r_n, r_k, r_m};
          3'd3: if ({1'b0, w_idx} < LP_C_DEPTH) r_rdt <= 32'(r_mem_c[w_idx[C_AW-1:0]]);
          3'd4: if (w_idx == 8'd0) r_rdt <= {28'd0, w_satf, r_err, w_busy, r_done};
          default: r_rdt <= '0;
        endcase
      end
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;

  // Address bits outside the decoded window, upper data bits and the unused
  // upper parts of the wide intermediates are intentionally left unconnected.
  logic w_unused;
  assign w_unused = ^{i_wb_adr, i_wb_dat, w_a_lin, w_b_lin, w_c_lin, r_acc, w_sat};

endmodule
